// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared definitions for the immediate-extension unit.
//   imm_mode_e : extension mode carried on the 2-bit mode field
//                (sign, zero, upper-immediate, branch-offset).
// -----------------------------------------------------------------------------
package imm_ext_pkg;

    typedef enum logic [1:0] {
        MODE_SEXT  = 2'd0,
        MODE_ZEXT  = 2'd1,
        MODE_LUI   = 2'd2,
        MODE_BROFF = 2'd3
    } imm_mode_e;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
// Purely combinational immediate extender.
// Ports:
//   imm  [IN_W-1:0]  in  raw immediate field
//   mode [1:0]       in  extension mode (imm_mode_e encoding)
//   data [OUT_W-1:0] out extended immediate
//   ovf              out branch offset not representable in OUT_W signed
// -----------------------------------------------------------------------------
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = 7,
    parameter int OUT_W    = 16,
    parameter int BR_SHIFT = 1
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] data,
    output logic             ovf
);

    // Wide enough to hold the shifted branch offset without losing any bit,
    // plus OUT_W so the result can always be sliced at OUT_W.
    localparam int WIDE_W = IN_W + BR_SHIFT + OUT_W;

    if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_width
        $error("imm_ext_core: IN_W must be in 1..OUT_W");
    end
    if (BR_SHIFT < 0 || BR_SHIFT > OUT_W - 1) begin : g_bad_shift
        $error("imm_ext_core: BR_SHIFT must be in 0..OUT_W-1");
    end

    logic signed [IN_W-1:0]         w_simm;
    logic        [OUT_W-1:0]        w_sext;
    logic        [OUT_W-1:0]        w_zext;
    logic        [OUT_W-1:0]        w_lui;
    logic        [WIDE_W-1:0]       w_br_wide;
    logic        [WIDE_W-OUT_W-1:0] w_br_high;

    // Casting a signed operand to a wider width sign-extends; casting an
    // unsigned one zero-extends. This also covers IN_W == OUT_W cleanly.
    assign w_simm    = imm;
    assign w_sext    = OUT_W'(w_simm);
    assign w_zext    = OUT_W'(imm);
    assign w_lui     = w_zext << (OUT_W - IN_W);
    assign w_br_wide = WIDE_W'(w_simm) << BR_SHIFT;
    // Everything above bit OUT_W-1 is discarded on truncation; the offset
    // survives only if all of it is a copy of the kept sign bit.
    assign w_br_high = w_br_wide[WIDE_W-1:OUT_W];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned, which would infer a latch.
        data = '0;
        ovf  = 1'b0;
        unique case (imm_mode_e'(mode))
            MODE_SEXT:  data = w_sext;
            MODE_ZEXT:  data = w_zext;
            MODE_LUI:   data = w_lui;
            MODE_BROFF: begin
                data = w_br_wide[OUT_W-1:0];
                ovf  = (w_br_high != {(WIDE_W-OUT_W){w_br_wide[OUT_W-1]}});
            end
        endcase
    end

endmodule : imm_ext_core

// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
// Registered immediate extender with valid/ready handshake and a 2-entry
// (main + skid) buffer so decode stalls never drop an immediate.
// Ports:
//   clk                 in  rising-edge clock
//   rst                 in  asynchronous active-high reset
//   in_valid            in  producer offers an immediate
//   in_ready            out unit can accept (skid entry empty; registered)
//   in_imm  [IN_W-1:0]  in  raw immediate field
//   in_mode [1:0]       in  extension mode (imm_mode_e encoding)
//   out_valid           out out_data/out_ovf hold a result
//   out_ready           in  consumer takes the result this cycle
//   out_data[OUT_W-1:0] out extended immediate
//   out_ovf             out branch-offset overflow flag
// -----------------------------------------------------------------------------
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = 7,
    parameter int OUT_W    = 16,
    parameter int BR_SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    logic [OUT_W-1:0] w_ext_data;
    logic             w_ext_ovf;
    logic             w_accept;
    logic             w_pop;
    logic             w_main_free;

    logic [OUT_W-1:0] r_main_data;
    logic             r_main_ovf;
    logic             r_main_valid;
    logic [OUT_W-1:0] r_skid_data;
    logic             r_skid_ovf;
    logic             r_skid_valid;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (w_ext_data),
        .ovf  (w_ext_ovf)
    );

    // in_ready depends only on a register, so there is no combinational
    // path from out_ready back to the producer.
    assign in_ready    = !r_skid_valid;
    assign w_accept    = in_valid && in_ready;
    assign w_pop       = r_main_valid && out_ready;
    assign w_main_free = !r_main_valid || w_pop;

    // NOTE: the skid entry is reset along with the main entry; it is only two
    // words, and a known value keeps the outputs clean after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_data  <= '0;
            r_main_ovf   <= 1'b0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ovf   <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            // NOTE: non-blocking assignments let main read the old skid value
            // while skid is overwritten in the same edge.
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_ovf   <= r_skid_ovf;
                r_main_valid <= 1'b1;
                if (w_accept) begin
                    r_skid_data <= w_ext_data;
                    r_skid_ovf  <= w_ext_ovf;
                end else begin
                    r_skid_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_main_data  <= w_ext_data;
                r_main_ovf   <= w_ext_ovf;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_data  <= w_ext_data;
            r_skid_ovf   <= w_ext_ovf;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_ovf   = r_main_ovf;

endmodule : imm_extend_pipe

// File: tb/tb_imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_pipe
// Drives two instances in lockstep: the default configuration and one with
// OUT_W=8, BR_SHIFT=2. Directed table, backpressure and reset sequences,
// then a randomised handshake run against a queue reference model.
// -----------------------------------------------------------------------------
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [6:0]  in_imm;
    logic [1:0]  in_mode;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ovf;

    logic        in_ready_b;
    logic        out_valid_b;
    logic [7:0]  out_data_b;
    logic        out_ovf_b;

    int checks   = 0;
    int failures = 0;

    imm_extend_pipe #(.IN_W(7), .OUT_W(16), .BR_SHIFT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    imm_extend_pipe #(.IN_W(7), .OUT_W(8), .BR_SHIFT(2)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_data  (out_data_b),
        .out_ovf   (out_ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: integer value of the result, then wrap/range test.
    function automatic logic [16:0] model(input logic [1:0] mode, input logic [6:0] imm,
                                          input int out_w, input int br);
        longint s;
        longint v;
        longint mask;
        logic [16:0] r;
        s = imm[6] ? longint'(imm) - 128 : longint'(imm);
        case (mode)
            2'd0:    v = s;
            2'd1:    v = longint'(imm);
            2'd2:    v = longint'(imm) * (longint'(1) << (out_w - 7));
            default: v = s * (longint'(1) << br);
        endcase
        mask     = (longint'(1) << out_w) - 1;
        r[15:0]  = 16'(v & mask);
        r[16]    = (mode == 2'd3) &&
                   (v < -(longint'(1) << (out_w - 1)) || v >= (longint'(1) << (out_w - 1)));
        return r;
    endfunction

    typedef struct {
        logic [1:0]  mode;
        logic [6:0]  imm;
        logic [15:0] d16;
        logic        o16;
        logic [7:0]  d8;
        logic        o8;
    } vec_t;

    typedef struct {
        logic [15:0] d16;
        logic        o16;
        logic [7:0]  d8;
        logic        o8;
    } exp_t;

    localparam int NVEC = 13;
    localparam int NRND = 10000;
    vec_t vecs [NVEC];
    exp_t q [$];

    initial begin
        vecs[0]  = '{2'd0, 7'h40, 16'hFFC0, 1'b0, 8'hC0, 1'b0};
        vecs[1]  = '{2'd1, 7'h40, 16'h0040, 1'b0, 8'h40, 1'b0};
        vecs[2]  = '{2'd2, 7'h40, 16'h8000, 1'b0, 8'h80, 1'b0};
        vecs[3]  = '{2'd3, 7'h40, 16'hFF80, 1'b0, 8'h00, 1'b1};
        vecs[4]  = '{2'd3, 7'h7F, 16'hFFFE, 1'b0, 8'hFC, 1'b0};
        vecs[5]  = '{2'd3, 7'h3F, 16'h007E, 1'b0, 8'hFC, 1'b1};
        vecs[6]  = '{2'd3, 7'h20, 16'h0040, 1'b0, 8'h80, 1'b1};
        vecs[7]  = '{2'd3, 7'h0F, 16'h001E, 1'b0, 8'h3C, 1'b0};
        vecs[8]  = '{2'd3, 7'h60, 16'hFFC0, 1'b0, 8'h80, 1'b0};
        vecs[9]  = '{2'd0, 7'h3F, 16'h003F, 1'b0, 8'h3F, 1'b0};
        vecs[10] = '{2'd1, 7'h7F, 16'h007F, 1'b0, 8'h7F, 1'b0};
        vecs[11] = '{2'd2, 7'h01, 16'h0200, 1'b0, 8'h02, 1'b0};
        vecs[12] = '{2'd0, 7'h00, 16'h0000, 1'b0, 8'h00, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        out_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Directed table, one per cycle; each result checked one cycle after accept.
        for (int i = 0; i <= NVEC; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("vec%0d_valid", i-1), out_valid, 1);
                check($sformatf("vec%0d_data16", i-1), out_data, vecs[i-1].d16);
                check($sformatf("vec%0d_ovf16", i-1), out_ovf, vecs[i-1].o16);
                check($sformatf("vec%0d_data8", i-1), out_data_b, vecs[i-1].d8);
                check($sformatf("vec%0d_ovf8", i-1), out_ovf_b, vecs[i-1].o8);
            end else begin
                check("idle_out_valid", out_valid, 0);
            end
            if (i < NVEC) begin
                in_valid = 1'b1;
                in_imm   = vecs[i].imm;
                in_mode  = vecs[i].mode;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("drained_valid", out_valid, 0);

        // Backpressure: A to main, B to skid, C held off.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_mode = 2'd0; in_imm = 7'h01;
        @(negedge clk);
        check("bp_ready_after_a", in_ready, 1);
        in_imm = 7'h02;
        @(negedge clk);
        check("bp_ready_after_b", in_ready, 0);
        check("bp_main_a", out_data, 16'h0001);
        in_imm = 7'h03;
        @(negedge clk);
        check("bp_hold_a", out_data, 16'h0001);
        check("bp_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_b", out_data, 16'h0002);
        check("bp_ready_back", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_out_c", out_data, 16'h0003);
        check("bp_out_c_valid", out_valid, 1);
        @(negedge clk);
        check("bp_empty", out_valid, 0);

        // Async reset with both entries full.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_imm = 7'h11;
        @(negedge clk);
        in_imm = 7'h12;
        @(negedge clk);
        in_valid = 1'b0;
        check("rr_full", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("rr_async_valid", out_valid, 0);
        check("rr_async_data", out_data, 0);
        check("rr_async_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        check("rr_release_valid", out_valid, 0);
        in_valid = 1'b1; in_imm = 7'h05; in_mode = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        check("rr_first_valid", out_valid, 1);
        check("rr_first_data", out_data, 16'h0005);
        @(negedge clk);
        check("rr_no_ghost", out_valid, 0);

        // Random handshake against a queue model.
        begin
            int sent = 0;
            int cycles = 0;
            logic prev_stall = 1'b0;
            logic [15:0] prev_d16 = '0;
            logic [7:0] prev_d8 = '0;
            while ((sent < NRND || q.size() > 0) && cycles < 60000) begin
                @(negedge clk);
                cycles++;
                check("rnd_out_valid", out_valid, (q.size() > 0) ? 1 : 0);
                check("rnd_in_ready", in_ready, (q.size() < 2) ? 1 : 0);
                if (prev_stall) begin
                    check("rnd_stable16", out_data, prev_d16);
                    check("rnd_stable8", out_data_b, prev_d8);
                end
                in_valid  = (sent < NRND) && ($urandom_range(0, 9) < 7);
                in_imm    = 7'($urandom);
                in_mode   = 2'($urandom);
                out_ready = ($urandom_range(0, 9) < 7);
                #1;
                if (out_valid && out_ready && q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("rnd_data16", out_data, e.d16);
                    check("rnd_ovf16", out_ovf, e.o16);
                    check("rnd_data8", out_data_b, e.d8);
                    check("rnd_ovf8", out_ovf_b, e.o8);
                end
                if (in_valid && in_ready) begin
                    logic [16:0] m16;
                    logic [16:0] m8;
                    m16 = model(in_mode, in_imm, 16, 1);
                    m8  = model(in_mode, in_imm, 8, 2);
                    q.push_back('{m16[15:0], m16[16], m8[7:0], m8[16]});
                    sent++;
                end
                prev_stall = out_valid && !out_ready;
                prev_d16   = out_data;
                prev_d8    = out_data_b;
            end
            check("rnd_all_sent", sent, NRND);
            check("rnd_queue_drained", q.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imm_extend_pipe

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, registered immediate-extension unit for the MIPS datapath. It generalises the fixed 7-to-16 sign extender to any input and output width. It supports four extension modes (sign, zero, upper-immediate, branch-offset) and reports overflow in branch-offset mode. It sits between decode and the ALU-operand mux, with a valid/ready handshake and a 2-entry skid buffer so that stalls do not drop immediates.

Parameters:
IN_W, 7, immediate field width; legal range 1..OUT_W.
OUT_W, 16, datapath word width; OUT_W >= IN_W (elaboration error otherwise).
BR_SHIFT, 1, left shift applied in branch-offset mode; legal range 0..OUT_W-1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  producer has an immediate this cycle.
in_ready  output  1  unit can accept; equals NOT skid_valid (register-driven, no combinational path from out_ready).
in_imm  input  IN_W  raw immediate field.
in_mode  input  2  0=SEXT, 1=ZEXT, 2=LUI, 3=BROFF.
out_valid  output  1  out_data/out_ovf hold a result.
out_ready  input  1  consumer takes the result this cycle.
out_data  output  OUT_W  extended immediate.
out_ovf  output  1  BROFF result not representable in OUT_W signed; 0 in all other modes.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_ovf=0, skid_valid=0, skid contents=0. in_ready=1 during and after reset.
- Handshake definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Compute rules (combinational, applied to the input before it is registered):
  - SEXT: {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
  - ZEXT: {(OUT_W-IN_W){0}, imm}.
  - LUI: imm << (OUT_W-IN_W). The immediate fills the top bits; lower bits are 0. When IN_W==OUT_W the result is imm.
  - BROFF: full = sign-extend imm to IN_W+BR_SHIFT bits, then << BR_SHIFT. out_data = sign-extend or truncate full to OUT_W. out_ovf=1 iff full cannot be represented in OUT_W bits two's complement, i.e. the discarded bits are not all equal to out_data[OUT_W-1].
- Storage: a main register drives the outputs; a skid register stores {data, ovf}.
- Register update (main_free = !out_valid | pop):
  - main_free & skid_valid: main <= skid. If accept, the new input goes to skid (skid_valid stays 1); otherwise skid_valid <= 0.
  - main_free & !skid_valid: if accept, main <= new input and out_valid <= 1; otherwise out_valid <= 0.
  - !main_free & accept: skid <= new input, skid_valid <= 1.
  - !main_free & !accept: hold.
- Timing and ordering: latency is 1 cycle from accept to out_valid with an empty pipe. Throughput is 1 per cycle while out_ready=1. Strict FIFO order is kept.
- Output stability: out_data and out_ovf stay stable while out_valid=1 and out_ready=0.
- Ignored inputs: in_imm and in_mode are don't-care when in_valid=0 or in_ready=0. The unit never accepts while in_ready=0.
- Reset mid-operation: both entries are discarded immediately (asynchronously); no partial output follows reset release.
- Simultaneous pop and accept with both entries full: in_ready=0, so accept cannot occur. Skid moves to main, and in_ready rises the next cycle.

Decomposition:
- Package imm_ext_pkg: mode constants MODE_SEXT=2'd0, MODE_ZEXT=2'd1, MODE_LUI=2'd2, MODE_BROFF=2'd3.
- Sub-module imm_ext_core (purely combinational): parameters IN_W/OUT_W/BR_SHIFT; inputs imm and mode; outputs data and ovf.
- imm_extend_pipe instantiates imm_ext_core once and holds the main/skid registers and the handshake logic.

Test Plan:
- Defaults, out_ready=1, in_imm=7'h40, mode SEXT/ZEXT/LUI/BROFF on consecutive cycles -> out_data 16'hFFC0, 16'h0040, 16'h8000, 16'hFF80. out_ovf=0 for all; one result per cycle, each 1 cycle after its accept.
- Defaults, BROFF with in_imm=7'h7F -> 16'hFFFE, ovf=0. With in_imm=7'h3F -> 16'h007E, ovf=0.
- OUT_W=8, IN_W=7, BR_SHIFT=2, BROFF: in_imm=7'h20 -> out_data 8'h80, ovf=1. in_imm=7'h0F -> 8'h3C, ovf=0. in_imm=7'h60 -> 8'h80, ovf=0.
- Backpressure: out_ready=0, push A=7'h01, B=7'h02, C=7'h03 (SEXT) -> A is in main, B is in skid, in_ready=0 from the cycle after B, and C is held. Raise out_ready -> outputs 0001, 0002, 0003 in order with no loss or duplication.
- Assert rst for 1 cycle while both entries are full (async edge between clocks) -> out_valid=0, out_data=0, and in_ready=1 immediately. The first post-reset input appears 1 cycle after its accept.
- Random valid/ready toggling over 10k transactions against a reference queue model -> order, data and ovf match. Assertions hold: out_data is stable while stalled, and accept never occurs while in_ready=0.
